// File: rtl/mc_ctrl.sv
// mc_ctrl: Moore multi-cycle control FSM for the MIPS-subset CPU, with
// memory ready handshakes and a wait-timeout watchdog.
module mc_ctrl #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       ir_we,
  output logic       pc_we,
  output logic       is_beq,
  output logic       is_jal,
  output logic       is_jr,
  output logic [1:0] alu_op,
  output logic       alu_src_imm,
  output logic [1:0] ext_sel,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       retired,
  output logic       illegal,
  output logic       bus_err
);
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR, MEM_RD,
    WB_MEM, MEM_WR, BRANCH, JAL, JR, NOP, HALT
  } state_t;
  state_t      state_q, state_d;
  logic        var_q, var_d;
  logic [15:0] cnt_q, cnt_d;
  logic        illegal_q, illegal_d;
  logic        bus_err_q, bus_err_d;
  logic        waiting, ready, timeout;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      var_q     <= 1'b0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      var_q     <= var_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end
  assign waiting = state_q inside {FETCH, MEM_RD, MEM_WR};
  assign ready   = (state_q == FETCH) ? imem_ready : dmem_ready;
  assign timeout = waiting && !ready && cnt_q == 16'(WAIT_LIMIT - 1);
  assign cnt_d   = (waiting && !ready && !timeout) ? cnt_q + 16'd1 : '0;
  // var_q remembers the variant decoded in DECODE: subu, lui or sw
  always_comb begin
    state_d   = state_q;
    var_d     = var_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    case (state_q)
      FETCH:    state_d = imem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          6'b000000: begin
            case (funct)
              6'b100001: begin state_d = EXEC_R; var_d = 1'b0; end
              6'b100011: begin state_d = EXEC_R; var_d = 1'b1; end
              6'b001000: state_d = JR;
              6'b000000: state_d = NOP;
              default:   begin state_d = HALT; illegal_d = 1'b1; end
            endcase
          end
          6'b001101: begin state_d = EXEC_I;   var_d = 1'b0; end
          6'b001111: begin state_d = EXEC_I;   var_d = 1'b1; end
          6'b100011: begin state_d = MEM_ADDR; var_d = 1'b0; end
          6'b101011: begin state_d = MEM_ADDR; var_d = 1'b1; end
          6'b000100: state_d = BRANCH;
          6'b000011: state_d = JAL;
          default:   begin state_d = HALT; illegal_d = 1'b1; end
        endcase
      end
      EXEC_R:   state_d = WB_R;
      EXEC_I:   state_d = WB_I;
      MEM_ADDR: state_d = var_q ? MEM_WR : MEM_RD;
      MEM_RD:   state_d = dmem_ready ? WB_MEM : MEM_RD;
      MEM_WR:   state_d = dmem_ready ? FETCH : MEM_WR;
      WB_R, WB_I, WB_MEM, BRANCH, JAL, JR, NOP: state_d = FETCH;
      default:  ;
    endcase
    if (timeout) begin
      state_d   = HALT;
      bus_err_d = 1'b1;
    end
  end
  always_comb begin
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    is_beq      = 1'b0;
    is_jal      = 1'b0;
    is_jr       = 1'b0;
    alu_op      = 2'b00;
    alu_src_imm = 1'b0;
    ext_sel     = 2'b00;
    reg_we      = 1'b0;
    reg_dst     = 2'b00;
    wd_sel      = 2'b00;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready && !reset;
      end
      EXEC_R:  alu_op = var_q ? 2'b01 : 2'b00;
      WB_R: begin
        alu_op  = var_q ? 2'b01 : 2'b00;
        reg_we  = 1'b1;
        reg_dst = 2'b01;
        pc_we   = 1'b1;
      end
      EXEC_I: begin
        alu_op      = var_q ? 2'b00 : 2'b10;
        ext_sel     = var_q ? 2'b10 : 2'b00;
        alu_src_imm = 1'b1;
      end
      WB_I: begin
        alu_op      = var_q ? 2'b00 : 2'b10;
        ext_sel     = var_q ? 2'b10 : 2'b00;
        alu_src_imm = 1'b1;
        reg_we      = 1'b1;
        pc_we       = 1'b1;
      end
      MEM_ADDR, MEM_RD, MEM_WR: begin
        alu_src_imm = 1'b1;
        ext_sel     = 2'b01;
        dmem_req    = state_q != MEM_ADDR;
        dmem_we     = state_q == MEM_WR;
        pc_we       = state_q == MEM_WR && dmem_ready;
      end
      WB_MEM: begin
        reg_we = 1'b1;
        wd_sel = 2'b01;
        pc_we  = 1'b1;
      end
      BRANCH: begin
        alu_op = 2'b01;
        is_beq = 1'b1;
        pc_we  = 1'b1;
      end
      JAL: begin
        is_jal  = 1'b1;
        reg_we  = 1'b1;
        reg_dst = 2'b10;
        wd_sel  = 2'b10;
        pc_we   = 1'b1;
      end
      JR: begin
        is_jr = 1'b1;
        pc_we = 1'b1;
      end
      NOP:     pc_we = 1'b1;
      default: ;
    endcase
    retired = pc_we;
  end
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed and randomized checks of mc_ctrl against a
// per-instruction latency / control-signature model.
module tb_mc_ctrl;
  logic       clk = 1'b0, reset = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic       imem_ready = 1'b0, dmem_ready = 1'b0;
  logic       imem_req, ir_we, pc_we, is_beq, is_jal, is_jr;
  logic [1:0] alu_op, ext_sel, reg_dst, wd_sel;
  logic       alu_src_imm, reg_we, dmem_req, dmem_we, retired, illegal, bus_err;
  int         errors = 0, checks = 0;

  mc_ctrl #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we),
    .is_beq(is_beq), .is_jal(is_jal), .is_jr(is_jr),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .ext_sel(ext_sel),
    .reg_we(reg_we), .reg_dst(reg_dst), .wd_sel(wd_sel),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .retired(retired),
    .illegal(illegal), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // index: addu subu jr nop ori lui lw sw beq jal
  logic [5:0] op_t [10] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b001101,
                            6'b001111, 6'b100011, 6'b101011, 6'b000100, 6'b000011};
  logic [5:0] fn_t [10] = '{6'b100001, 6'b100011, 6'b001000, 6'b000000, 6'b000000,
                            6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000};
  int         lat_t [10] = '{4, 4, 3, 3, 4, 4, 5, 4, 3, 3};
  int         mem_t [10] = '{0, 0, 0, 0, 0, 0, 1, 2, 0, 0};
  // commit cycle: {reg_we, reg_dst, wd_sel, is_beq, is_jal, is_jr}
  logic [7:0] sig_t [10] = '{8'b1_01_00_000, 8'b1_01_00_000, 8'b0_00_00_001, 8'b0_00_00_000,
                             8'b1_00_00_000, 8'b1_00_00_000, 8'b1_00_01_000, 8'b0_00_00_000,
                             8'b0_00_00_100, 8'b1_10_10_010};
  // third cycle after fetch: {alu_op, alu_src_imm, ext_sel}
  logic [7:0] alu_t [10] = '{8'b00000, 8'b01000, 8'b00000, 8'b00000, 8'b10100,
                             8'b00110, 8'b00101, 8'b00101, 8'b01000, 8'b00000};

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
    #1;
    chk1("rst_imem_req", imem_req, 1'b1);
    chk1("rst_ir_we", ir_we, 1'b0);
    chk1("rst_pc_we", pc_we, 1'b0);
    chk1("rst_reg_we", reg_we, 1'b0);
    chk1("rst_dmem_req", dmem_req, 1'b0);
    chk1("rst_illegal", illegal, 1'b0);
    chk1("rst_bus_err", bus_err, 1'b0);
  endtask

  task automatic run_instr(input int k, input int fw, input int mw);
    int ms, total, memk;
    logic [5:0] fn;
    memk  = mem_t[k];
    ms    = fw + 3;
    total = lat_t[k] + fw + (memk != 0 ? mw : 0);
    fn    = (op_t[k] == 6'b0) ? fn_t[k] : 6'($urandom);
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      reset      = 1'b0;
      opcode     = op_t[k];
      funct      = fn;
      imem_ready = (c < fw) ? 1'b0 : (c == fw) ? 1'b1 : 1'($urandom);
      dmem_ready = (memk != 0 && c >= ms) ? (c == ms + mw) : 1'($urandom);
      #1;
      chk1("imem_req", imem_req, c <= fw);
      chk1("ir_we", ir_we, c == fw);
      chk1("pc_we", pc_we, c == total - 1);
      chk1("retired", retired, c == total - 1);
      chk1("reg_we", reg_we, c == total - 1 && sig_t[k][7]);
      chk1("dmem_req", dmem_req, memk != 0 && c >= ms && c <= ms + mw);
      chk1("dmem_we", dmem_we, memk == 2 && c >= ms && c <= ms + mw);
      chk1("sel_onehot", $countones({is_beq, is_jal, is_jr}) <= 1, 1'b1);
      if (c == fw + 2) chk8("alu_ctl", {3'b0, alu_op, alu_src_imm, ext_sel}, alu_t[k]);
      if (c == total - 1) chk8("commit", {reg_we, reg_dst, wd_sel, is_beq, is_jal, is_jr}, sig_t[k]);
    end
  endtask

  initial begin
    do_reset();
    run_instr(0, 0, 0);
    run_instr(6, 0, 3);
    run_instr(8, 0, 0);
    run_instr(9, 0, 0);
    run_instr(2, 0, 0);
    run_instr(1, 1, 0);
    run_instr(4, 0, 0);
    run_instr(5, 2, 0);
    run_instr(7, 0, 2);
    run_instr(3, 0, 0);
    // undecodable opcode parks in HALT
    for (int c = 0; c < 23; c++) begin
      @(negedge clk);
      reset = 1'b0; opcode = 6'b111111; funct = 6'b0; imem_ready = 1'b1;
      #1;
      if (c == 0) chk1("ill_ir_we", ir_we, 1'b1);
      if (c >= 1) chk1("ill_flag", illegal, c >= 2);
      if (c >= 2) begin
        chk1("ill_pc_we", pc_we, 1'b0);
        chk1("ill_imem_req", imem_req, 1'b0);
      end
    end
    // instruction memory never ready
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      reset = 1'b0; imem_ready = 1'b0;
      #1;
      chk1("to_imem_req", imem_req, c < 4);
      chk1("to_bus_err", bus_err, c >= 4);
    end
    do_reset();
    run_instr(0, 3, 0);
    chk1("late_ready_bus_err", bus_err, 1'b0);
    // reset during MEM_WR
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      reset = 1'b0; opcode = 6'b101011; imem_ready = (c == 0); dmem_ready = 1'b0;
      #1;
    end
    chk1("memwr_dmem_we", dmem_we, 1'b1);
    @(negedge clk);
    reset = 1'b1; dmem_ready = 1'b1;
    #1;
    chk1("abort_imem_req", imem_req, 1'b1);
    chk1("abort_dmem_we", dmem_we, 1'b0);
    chk1("abort_dmem_req", dmem_req, 1'b0);
    chk1("abort_pc_we", pc_we, 1'b0);
    chk1("abort_retired", retired, 1'b0);
    chk1("abort_reg_we", reg_we, 1'b0);
    // random instruction stream with random ready delays
    for (int n = 0; n < 150; n++)
      run_instr(int'($urandom_range(0, 9)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    chk1("final_illegal", illegal, 1'b0);
    chk1("final_bus_err", bus_err, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Moore-style multi-cycle control FSM for the MIPS-subset CPU. It sequences fetch, decode, execute, memory and writeback for each instruction. It drives the next-PC unit's is_beq/is_jal/is_jr selects and commits the PC exactly once per instruction. Sits between the instruction register decode fields and the datapath (PC, IR, GRF, ALU, EXT, DM), with ready handshakes on the instruction and data memories and a wait-timeout watchdog.

Parameters:
WAIT_LIMIT, 255, max consecutive cycles a memory request may wait for ready before bus error (1..65535)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; forces state FETCH, clears counters/flags
opcode  in  6  IR[31:26], valid from DECODE onward
funct  in  6  IR[5:0]
imem_ready  in  1  instruction word valid this cycle
dmem_ready  in  1  data access complete this cycle
imem_req  out  1  instruction fetch request
ir_we  out  1  IR load enable
pc_we  out  1  PC load enable (takes next-PC unit output)
is_beq  out  1  next-PC branch select
is_jal  out  1  next-PC jal select
is_jr  out  1  next-PC jr select
alu_op  out  2  00 add, 01 sub, 10 or
alu_src_imm  out  1  ALU B = EXT output
ext_sel  out  2  00 zero-ext, 01 sign-ext, 10 lui (imm<<16)
reg_we  out  1  GRF write enable
reg_dst  out  2  00 rt, 01 rd, 10 $31
wd_sel  out  2  00 ALU, 01 DM read data, 10 PC+4
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write
retired  out  1  one-cycle pulse when pc_we commits an instruction
illegal  out  1  sticky: undecodable instruction seen
bus_err  out  1  sticky: memory wait exceeded WAIT_LIMIT

Behaviour:
- States: FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, JAL, JR, NOP, HALT.
- Outputs are a function of state only, except ir_we/pc_we/retired, which are also gated by ready where noted. Every output is 0 unless listed. ALU/EXT/reg_dst/wd_sel are held stable for the whole of a state.
- Reset (async): state=FETCH, wait counter=0, illegal=0, bus_err=0. All outputs take FETCH values, so imem_req=1 and everything else is 0.
- FETCH: imem_req=1; ir_we=imem_ready; advance to DECODE on imem_ready, else stay.
- DECODE: no outputs. Decode table:
  - opcode 000000 with funct 100001/100011 (addu/subu) -> EXEC_R
  - funct 001000 (jr) -> JR
  - funct 000000 (nop/sll) -> NOP
  - 001101 ori, 001111 lui -> EXEC_I
  - 100011 lw, 101011 sw -> MEM_ADDR
  - 000100 beq -> BRANCH
  - 000011 jal -> JAL
  - anything else -> HALT, set illegal
- EXEC_R: alu_op = 00 for addu, 01 for subu. WB_R: same alu_op, reg_we=1, reg_dst=01, wd_sel=00, pc_we=1 -> FETCH.
- EXEC_I / WB_I: ori uses alu_op=10, ext_sel=00; lui uses alu_op=00 (add $0), ext_sel=10; both with alu_src_imm=1. WB_I adds reg_we=1, reg_dst=00, wd_sel=00, pc_we=1 -> FETCH.
- MEM_ADDR: alu_op=00, alu_src_imm=1, ext_sel=01 -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: address controls held; dmem_req=1; -> WB_MEM on dmem_ready.
- WB_MEM: reg_we=1, reg_dst=00, wd_sel=01, pc_we=1 -> FETCH.
- MEM_WR: address controls held; dmem_req=1, dmem_we=1; pc_we=dmem_ready; -> FETCH on dmem_ready.
- BRANCH: alu_op=01, is_beq=1, pc_we=1 -> FETCH. The next-PC unit applies zero; the controller does not read it.
- JAL: is_jal=1, reg_we=1, reg_dst=10, wd_sel=10, pc_we=1 -> FETCH. JR: is_jr=1, pc_we=1 -> FETCH. NOP: pc_we=1 -> FETCH.
- At most one of is_beq/is_jal/is_jr is high in any cycle.
- retired = pc_we, in the same cycle.
- Latency with zero wait: beq/jal/jr/nop 3 cycles; R-type, ori, lui, sw 4; lw 5. Each ready-low cycle adds 1.
- Wait counter: increments each cycle in FETCH/MEM_RD/MEM_WR while ready is low; clears on ready or on state change. If ready is still low when the counter reaches WAIT_LIMIT -> HALT, set bus_err. Ready arriving in the WAIT_LIMIT-th cycle is accepted normally.
- HALT: all outputs 0 except the sticky flags; remains until reset.
- Reset mid-instruction aborts immediately. No pc_we, reg_we or dmem_we appears in the reset cycle.

Test Plan:
- Reset held, then released with imem_ready=1 and IR=addu (000000/100001) -> ir_we @c0, EXEC_R @c2 with alu_op=00, WB_R @c3 with reg_we=1, reg_dst=01, pc_we=1, retired=1. 4 cycles.
- lw with dmem_ready low 3 cycles -> MEM_RD lasts 4 cycles with dmem_req=1 and dmem_we=0; WB_MEM wd_sel=01, pc_we=1. Total 8 cycles.
- beq, jal, jr back-to-back -> each 3 cycles. is_beq / is_jal / is_jr are one-hot in the final cycle. jal has reg_dst=10 and wd_sel=10.
- opcode 111111 -> HALT after DECODE, illegal=1. No pc_we afterwards, even with imem_ready=1 for 20 cycles.
- imem_ready never asserted, WAIT_LIMIT=4 -> bus_err=1 and HALT after 4 wait cycles. A second run with ready on the 4th cycle completes normally.
- Assert reset during MEM_WR -> all outputs go to FETCH values the same cycle, and dmem_we=0.
